// File: rtl/pong_ball.sv
// pong_ball: ball position, bounces, paddle hits, point detection and ball-pixel flag (optional PONG_BALL_SPEEDUP_EN)
module pong_ball #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int BALL_SIZE   = 8,
  parameter int SPEED       = 2,
  parameter int MAX_SPEED   = 6,
  parameter int PADDLE_X_L  = 16,
  parameter int PADDLE_X_R  = 616,
  parameter int PADDLE_W    = 8,
  parameter int PADDLE_H    = 64,
  parameter int HOLD_FRAMES = 60
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pix_stb,
  input  logic       i_animate,
  input  logic [9:0] i_x,
  input  logic [8:0] i_y,
  input  logic [8:0] i_paddle_l_y,
  input  logic [8:0] i_paddle_r_y,
  input  logic       i_serve,
  output logic       o_ball_pix,
  output logic [9:0] o_ball_x,
  output logic [8:0] o_ball_y,
  output logic       o_point_l,
  output logic       o_point_r,
  output logic [1:0] o_state
);
  localparam int SW = $clog2(((MAX_SPEED > SPEED) ? MAX_SPEED : SPEED) + 1);
  localparam int HW = $clog2(HOLD_FRAMES);
  localparam logic [1:0] IDLE = 2'd0, MOVE = 2'd1, SCORED = 2'd2;
  localparam logic [10:0] BS  = 11'(BALL_SIZE);
  localparam logic [10:0] HR  = 11'(H_RES);
  localparam logic [10:0] VR  = 11'(V_RES);
  localparam logic [10:0] PXR = 11'(PADDLE_X_R);
  localparam logic [10:0] EL  = 11'(PADDLE_X_L + PADDLE_W);
  localparam logic [10:0] PH  = 11'(PADDLE_H);
  localparam logic [9:0]  X0  = 10'((H_RES - BALL_SIZE) / 2);
  localparam logic [8:0]  Y0  = 9'((V_RES - BALL_SIZE) / 2);

  logic [1:0] state, state_nx;
  logic [9:0] ball_x, x_nx;
  logic [8:0] ball_y, y_nx;
  logic dx, dy, exit_r, tick, visible, hold_done;
  logic [SW-1:0] speed;
  logic [HW-1:0] hold;
  logic [10:0] x, y, sp, pl, pr, px, py;
  logic down_hit, up_hit, ov_l, ov_r, hit_l, hit_r, miss_l, miss_r, miss, in_x, in_y;

  assign tick = i_pix_stb & i_animate;
  assign x = {1'b0, ball_x};
  assign y = {2'b0, ball_y};
  assign sp = 11'(speed);
  assign pl = {2'b0, i_paddle_l_y};
  assign pr = {2'b0, i_paddle_r_y};
  assign px = {1'b0, i_x};
  assign py = {2'b0, i_y};
  assign hold_done = hold == HW'(HOLD_FRAMES - 1);

  assign down_hit = y + BS + sp >= VR;
  assign up_hit = y <= sp;
  assign y_nx = 9'(dy ? (down_hit ? VR - BS : y + sp) : (up_hit ? 11'd0 : y - sp));
  assign ov_r = (y + BS > pr) && (y < pr + PH);
  assign ov_l = (y + BS > pl) && (y < pl + PH);
  assign hit_r = dx && (x + BS <= PXR) && (x + sp + BS >= PXR) && ov_r;
  assign miss_r = dx && !hit_r && (x + sp + BS >= HR);
  assign hit_l = !dx && (x >= EL) && (x - sp <= EL) && ov_l;
  assign miss_l = !dx && !hit_l && (x <= sp);
  assign miss = miss_r | miss_l;
  assign x_nx = 10'(hit_r ? PXR - BS : hit_l ? EL : dx ? x + sp : x - sp);
  assign in_x = (px >= x) && (px < x + BS);
  assign in_y = (py >= y) && (py < y + BS);

  assign o_ball_x = ball_x;
  assign o_ball_y = ball_y;

  // state register
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) state <= IDLE;
    else state <= state_nx;

  // next state: serve launches, a miss scores, hold expiry returns to idle
  always_comb begin
    state_nx = !tick ? state :
               (state == IDLE && i_serve) ? MOVE :
               (state == MOVE && miss) ? SCORED :
               (state == SCORED && hold_done) ? IDLE :
               (state == 2'd3) ? IDLE : state;
  end

  // state-derived outputs
  always_comb begin
    visible = state != SCORED;
    o_state = state;
  end

  // ball motion, direction and post-point hold/recentre
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      ball_x <= X0;
      ball_y <= Y0;
      dx <= 1'b1;
      dy <= 1'b1;
      exit_r <= 1'b0;
      hold <= '0;
    end else if (tick) begin
      if (state == MOVE && !miss) begin
        ball_x <= x_nx;
        ball_y <= y_nx;
        dx <= dx ^ (hit_r | hit_l);
        dy <= dy ^ (dy ? down_hit : up_hit);
      end
      if (state == MOVE && miss) exit_r <= miss_r;
      if (state == SCORED) begin
        hold <= hold_done ? '0 : hold + HW'(1);
        if (hold_done) begin
          ball_x <= X0;
          ball_y <= Y0;
          dy <= 1'b1;
          dx <= !exit_r;
        end
      end
    end

`ifdef PONG_BALL_SPEEDUP_EN
  // speed rises on each paddle hit up to the ceiling, restored after a point
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) speed <= SW'(SPEED);
    else if (tick && state == MOVE && (hit_r | hit_l)) speed <= (speed < SW'(MAX_SPEED)) ? speed + SW'(1) : SW'(MAX_SPEED);
    else if (tick && state == SCORED && hold_done) speed <= SW'(SPEED);
`else
  assign speed = SW'(SPEED);
`endif

  // registered pixel flag and one-clock point pulses
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      o_ball_pix <= 1'b0;
      o_point_l <= 1'b0;
      o_point_r <= 1'b0;
    end else begin
      o_point_l <= tick && state == MOVE && miss_r;
      o_point_r <= tick && state == MOVE && miss_l;
      if (i_pix_stb) o_ball_pix <= visible && in_x && in_y;
    end
endmodule

// File: tb/tb_pong_ball.sv
// tb_pong_ball: directed self-checking bench for pong_ball
module tb_pong_ball;
  logic i_clk = 1'b0, i_rst = 1'b1, i_pix_stb = 1'b1, i_animate = 1'b0, i_serve = 1'b0;
  logic [9:0] i_x = '0;
  logic [8:0] i_y = '0, i_paddle_l_y = '0, i_paddle_r_y = '0;
  logic o_ball_pix, o_point_l, o_point_r;
  logic [9:0] o_ball_x;
  logic [8:0] o_ball_y;
  logic [1:0] o_state;
  int tests = 0, failed = 0, pl_cnt = 0, pr_cnt = 0, both_cnt = 0;

  pong_ball dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_pix_stb(i_pix_stb), .i_animate(i_animate),
    .i_x(i_x), .i_y(i_y), .i_paddle_l_y(i_paddle_l_y), .i_paddle_r_y(i_paddle_r_y),
    .i_serve(i_serve), .o_ball_pix(o_ball_pix), .o_ball_x(o_ball_x), .o_ball_y(o_ball_y),
    .o_point_l(o_point_l), .o_point_r(o_point_r), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    pl_cnt <= pl_cnt + int'(o_point_l);
    pr_cnt <= pr_cnt + int'(o_point_r);
    both_cnt <= both_cnt + int'(o_point_l & o_point_r);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pos(input string tag, input int ex, input int ey);
    chk({tag, "_x"}, 32'(o_ball_x), ex);
    chk({tag, "_y"}, 32'(o_ball_y), ey);
  endtask

  task automatic tick();
    @(negedge i_clk) i_animate = 1'b1;
    @(negedge i_clk) i_animate = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pix(input int px, input int py);
    i_x = 10'(px);
    i_y = 9'(py);
    @(negedge i_clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge i_clk);
    chk("rst_state", 32'(o_state), 0);
    pos("rst", 316, 236);
    chk("rst_pix", 32'(o_ball_pix), 0);
    chk("rst_pl", 32'(o_point_l), 0);
    chk("rst_pr", 32'(o_point_r), 0);
    i_rst = 1'b0;
    pix(316, 236); chk("pix_tl", 32'(o_ball_pix), 1);
    pix(315, 236); chk("pix_left_out", 32'(o_ball_pix), 0);
    pix(323, 243); chk("pix_br", 32'(o_ball_pix), 1);
    pix(324, 243); chk("pix_right_out", 32'(o_ball_pix), 0);
    pix(323, 244); chk("pix_below_out", 32'(o_ball_pix), 0);
    i_x = 10'd320; i_y = 9'd240;
    chk("pix_latency", 32'(o_ball_pix), 0);
    @(negedge i_clk); chk("pix_mid", 32'(o_ball_pix), 1);
    i_pix_stb = 1'b0;
    pix(0, 0); chk("pix_hold_no_stb", 32'(o_ball_pix), 1);
    i_serve = 1'b1;
    tick(); chk("no_stb_no_tick", 32'(o_state), 0);
    i_pix_stb = 1'b1; i_serve = 1'b0;
    ticks(5);
    chk("idle_state", 32'(o_state), 0);
    pos("idle", 316, 236);
    i_paddle_r_y = 9'd408; i_paddle_l_y = 9'd150;
    i_serve = 1'b1; tick(); i_serve = 1'b0;
    chk("serve_state", 32'(o_state), 1);
    pos("serve", 316, 236);
    ticks(10); pos("move10", 336, 256);
    ticks(107); pos("near_floor", 550, 470);
    tick(); pos("floor_clamp", 552, 472);
    tick(); pos("floor_up", 554, 470);
    ticks(26); pos("pre_hit_r", 606, 418);
    tick(); pos("hit_r", 608, 416);
    chk("hit_r_no_point", 32'(o_point_l), 0);
    chk("hit_r_state", 32'(o_state), 1);
    ticks(208); pos("ceiling", 192, 0);
    ticks(84); pos("hit_l", 24, 168);
    i_paddle_r_y = 9'd0;
    ticks(303); pos("pre_miss_r", 630, 170);
    pix(630, 170); chk("pix_visible_move", 32'(o_ball_pix), 1);
    tick();
    chk("point_l_pulse", 32'(o_point_l), 1);
    chk("point_l_no_r", 32'(o_point_r), 0);
    chk("scored_state", 32'(o_state), 2);
    pos("scored_frozen", 630, 170);
    @(negedge i_clk);
    chk("point_l_one_clk", 32'(o_point_l), 0);
    chk("pix_hidden", 32'(o_ball_pix), 0);
    ticks(59); chk("hold59_state", 32'(o_state), 2);
    chk("hold59_pix", 32'(o_ball_pix), 0);
    tick(); chk("hold60_state", 32'(o_state), 0);
    pos("recentre", 316, 236);
    i_serve = 1'b1; tick(); i_serve = 1'b0;
    tick(); pos("serve_left", 314, 238);
    i_paddle_l_y = 9'd0;
    ticks(156); pos("pre_miss_l", 2, 394);
    tick();
    chk("point_r_pulse", 32'(o_point_r), 1);
    chk("point_r_no_l", 32'(o_point_l), 0);
    chk("scored_l_state", 32'(o_state), 2);
    ticks(60); chk("idle_again", 32'(o_state), 0);
    i_serve = 1'b1; tick(); i_serve = 1'b0;
    tick(); pos("serve_right", 318, 238);
    ticks(3); pos("pre_reset", 324, 244);
    @(negedge i_clk); #2 i_rst = 1'b1;
    #1;
    chk("midrst_state", 32'(o_state), 0);
    pos("midrst", 316, 236);
    chk("midrst_pix", 32'(o_ball_pix), 0);
    @(negedge i_clk) i_rst = 1'b0;
    chk("count_point_l", 32'(pl_cnt), 1);
    chk("count_point_r", 32'(pr_cnt), 1);
    chk("count_both", 32'(both_cnt), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
